// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for the register-file write arbiter: pipeline writeback,
// cache load return, load issue, decode queries and the write port.
interface wb_write_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          ld_valid;
    logic [4:0]    ld_rd;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic          ld_issue;
    logic [4:0]    ld_issue_rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd_q;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rd_busy;
    logic          rf_we;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;
    logic [CW-1:0] fifo_count;

    // Driven by the pipeline / cache / decode side.
    modport master (
        output wb_valid, wb_rd, wb_data,
        output ld_valid, ld_rd, ld_data,
        output ld_issue, ld_issue_rd,
        output rs1, rs2, rd_q,
        input  ld_ready, rs1_busy, rs2_busy, rd_busy,
        input  rf_we, rf_wa, rf_wd, fifo_count
    );

    // The arbiter itself.
    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  ld_valid, ld_rd, ld_data,
        input  ld_issue, ld_issue_rd,
        input  rs1, rs2, rd_q,
        output ld_ready, rs1_busy, rs2_busy, rd_busy,
        output rf_we, rf_wa, rf_wd, fifo_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter. The in-order pipeline always owns the
// port when it has a real write; load returns wait in a small FIFO and
// drain into idle slots. A pending-load scoreboard feeds decode stalls.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rst,
    wb_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_entry_t;

    ld_entry_t     fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pend;
    logic          src_ld;

    logic full;
    logic empty;
    logic wb_take;
    logic push;
    logic pop;
    logic [31:0] pend_nxt;

    // Occupancy flags come from the registered count only, so an entry
    // pushed this cycle cannot be popped until the next one, and a pop
    // this cycle never frees room for a push on a full FIFO.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        wb_take = bus.wb_valid && (bus.wb_rd != 5'd0);
        push    = bus.ld_valid && !full && (bus.ld_rd != 5'd0);
        pop     = !wb_take && !empty;
    end

    assign bus.ld_ready   = !full;
    assign bus.fifo_count = count;

    // FIFO storage; contents are don't-care while empty so no reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{rd: bus.ld_rd, data: bus.ld_data};
    end

    // FIFO pointers and occupancy; power-of-2 depth gives natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Registered write port: pipeline first, then FIFO head, else idle
    // with address/data held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rf_we <= 1'b0;
            bus.rf_wa <= 5'd0;
            bus.rf_wd <= 32'd0;
            src_ld    <= 1'b0;
        end else if (wb_take) begin
            bus.rf_we <= 1'b1;
            bus.rf_wa <= bus.wb_rd;
            bus.rf_wd <= bus.wb_data;
            src_ld    <= 1'b0;
        end else if (pop) begin
            bus.rf_we <= 1'b1;
            bus.rf_wa <= fifo_mem[rd_ptr].rd;
            bus.rf_wd <= fifo_mem[rd_ptr].data;
            src_ld    <= 1'b1;
        end else begin
            bus.rf_we <= 1'b0;
            src_ld    <= 1'b0;
        end
    end

    // Scoreboard update: a load write clears its bit on the same edge the
    // register file captures it; a new issue to that register wins.
    always_comb begin
        pend_nxt = pend;
        if (bus.rf_we && src_ld)
            pend_nxt[bus.rf_wa] = 1'b0;
        if (bus.ld_issue)
            pend_nxt[bus.ld_issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend <= 32'd0;
        else      pend <= pend_nxt;
    end

    // Decode queries read the scoreboard directly.
    always_comb begin
        bus.rs1_busy = pend[bus.rs1];
        bus.rs2_busy = pend[bus.rs2];
        bus.rd_busy  = pend[bus.rd_q];
    end
endmodule
